top2_arbiter: RTL and testbench

- Shares one top-2 (largest / second-largest) tracking engine between NUM_REQ requester streams.
- Each requester submits a burst of unsigned samples over a valid/ready/last handshake.
- The block grants bursts round-robin, computes largest and second-largest of the granted burst, and returns them on a result handshake tagged with the requester id.
- Sits between the sample producers and the downstream statistics consumer.

---
 rtl/top2_arbiter.sv | 150 +++++++++++++++
 tb/tb_top2_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/top2_arbiter.sv
// Round-robin arbiter sharing one largest/second-largest tracker across NUM_REQ sample bursts.
// Grant takes 1 cycle, one beat per cycle in RUN, result is held until res_ready. Macro TOP2_DISTINCT_EN keeps second strictly below largest.
module top2_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [$clog2(NUM_REQ)-1:0]    res_id,
    output logic [DATA_WIDTH-1:0]         res_largest,
    output logic [DATA_WIDTH-1:0]         res_second,
    output logic [CNT_WIDTH-1:0]          res_count,
    output logic                          busy
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int SW   = ID_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RESULT
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_W-1:0]       r_grant;
    logic [ID_W-1:0]       r_last_grant;
    logic [DATA_WIDTH-1:0] r_largest;
    logic [DATA_WIDTH-1:0] r_second;
    logic [CNT_WIDTH-1:0]  r_count;

    logic [ID_W-1:0]       w_pick;
    logic                  w_any;
    logic [SW-1:0]         w_sum;
    logic [DATA_WIDTH-1:0] w_lane [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_d;
    logic                  w_beat;
    logic                  w_take2;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_lane[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan from farthest to nearest candidate so the nearest one after last_grant wins.
    always_comb begin
        w_pick = r_last_grant;
        w_any  = 1'b0;
        w_sum  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_sum = {1'b0, r_last_grant} + SW'(k);
            if (w_sum >= SW'(NUM_REQ)) begin
                w_sum = w_sum - SW'(NUM_REQ);
            end
            if (req_valid[w_sum[ID_W-1:0]]) begin
                w_pick = w_sum[ID_W-1:0];
                w_any  = 1'b1;
            end
        end
    end

    assign w_d    = w_lane[r_grant];
    assign w_beat = (r_state == S_RUN) && req_valid[r_grant];

`ifdef TOP2_DISTINCT_EN
    assign w_take2 = (w_d > r_second) && (w_d != r_largest);
`else
    assign w_take2 = (w_d > r_second);
`endif

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_any) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                req_ready[r_grant] = 1'b1;
                if (w_beat && req_last[r_grant]) begin
                    w_state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant      <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_largest    <= '0;
            r_second     <= '0;
            r_count      <= '0;
        end else if ((r_state == S_IDLE) && w_any) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_largest    <= '0;
            r_second     <= '0;
            r_count      <= '0;
        end else if (w_beat) begin
            if (w_d > r_largest) begin
                r_second  <= r_largest;
                r_largest <= w_d;
            end else if (w_take2) begin
                r_second <= w_d;
            end
            // Count pins at all-ones once saturated.
            if (r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign res_id      = r_grant;
    assign res_largest = r_largest;
    assign res_second  = r_second;
    assign res_count   = r_count;

endmodule

// File: tb/tb_top2_arbiter.sv
// Directed bench for top2_arbiter: default instance plus a 4-bit-counter instance for saturation.
module tb_top2_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_last;
    logic [3:0]   req_ready;
    logic         res_valid;
    logic         res_ready;
    logic [1:0]   res_id;
    logic [31:0]  res_largest;
    logic [31:0]  res_second;
    logic [15:0]  res_count;
    logic         busy;

    logic [1:0]   s_valid;
    logic [15:0]  s_data;
    logic [1:0]   s_last;
    logic [1:0]   s_ready;
    logic         s_res_valid;
    logic         s_res_ready;
    logic [0:0]   s_res_id;
    logic [7:0]   s_largest;
    logic [7:0]   s_second;
    logic [3:0]   s_count;
    logic         s_busy;

    int n_assert = 0;
    int n_fail   = 0;

    top2_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_largest(res_largest), .res_second(res_second), .res_count(res_count), .busy(busy)
    );

    top2_arbiter #(.DATA_WIDTH(8), .NUM_REQ(2), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .reset(reset),
        .req_valid(s_valid), .req_data(s_data), .req_last(s_last), .req_ready(s_ready),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .res_id(s_res_id),
        .res_largest(s_largest), .res_second(s_second), .res_count(s_count), .busy(s_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one beat, hold it until ready, then drop valid on the following negedge.
    task automatic beat(input int id, input logic [31:0] d, input logic last);
        int t;
        t = 0;
        @(negedge clk);
        req_valid[id]         = 1'b1;
        req_data[id*32 +: 32] = d;
        req_last[id]          = last;
        while (!req_ready[id] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("beat_ready", 64'(req_ready[id]), 64'd1);
        @(negedge clk);
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic wait_result(input int id, input logic [31:0] lg, input logic [31:0] sc,
                               input logic [15:0] cnt);
        int t;
        t = 0;
        while (!res_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("res_valid", 64'(res_valid), 64'd1);
        check("res_id", 64'(res_id), 64'(id));
        check("res_largest", 64'(res_largest), 64'(lg));
        check("res_second", 64'(res_second), 64'(sc));
        check("res_count", 64'(res_count), 64'(cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int got;
        int t;
        int b;
        int exp_id;
        logic [31:0] exp_sec;

        reset       = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        res_ready   = 1'b1;
        s_valid     = '0;
        s_data      = '0;
        s_last      = '0;
        s_res_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_id", 64'(res_id), 64'd0);
        check("rst_largest", 64'(res_largest), 64'd0);
        check("rst_second", 64'(res_second), 64'd0);
        check("rst_count", 64'(res_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sat_busy", 64'(s_busy), 64'd0);
        reset = 1'b0;

        // Reset mid-RUN discards requester 2's partial burst
        beat(2, 32'd5, 1'b0);
        beat(2, 32'd9, 1'b0);
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_largest", 64'(res_largest), 64'd9);
        reset = 1'b1;
        #1;
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        check("mid_rst_res_valid", 64'(res_valid), 64'd0);
        check("mid_rst_res_id", 64'(res_id), 64'd0);
        check("mid_rst_largest", 64'(res_largest), 64'd0);
        check("mid_rst_second", 64'(res_second), 64'd0);
        check("mid_rst_count", 64'(res_count), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        beat(0, 32'd1, 1'b0);
        beat(0, 32'd3, 1'b1);
        wait_result(0, 32'd3, 32'd1, 16'd2);

        // Latency: continuous 3-beat burst from requester 0
        @(negedge clk);
        req_valid[0]     = 1'b1;
        req_data[31:0]   = 32'd2;
        req_last[0]      = 1'b0;
        @(negedge clk);
        check("lat_c1_res_valid", 64'(res_valid), 64'd0);
        check("lat_c1_req_ready", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_data[31:0]   = 32'd9;
        @(negedge clk);
        check("lat_c3_res_valid", 64'(res_valid), 64'd0);
        req_data[31:0]   = 32'd5;
        req_last[0]      = 1'b1;
        @(negedge clk);
        req_valid[0]     = 1'b0;
        req_last[0]      = 1'b0;
        check("lat_c4_res_valid", 64'(res_valid), 64'd1);
        check("lat_largest", 64'(res_largest), 64'd9);
        check("lat_second", 64'(res_second), 64'd5);
        check("lat_count", 64'(res_count), 64'd3);
        @(negedge clk);
        check("lat_c5_busy", 64'(busy), 64'd0);
        check("lat_c5_res_valid", 64'(res_valid), 64'd0);

        // Tracker ordering with a repeated maximum
`ifdef TOP2_DISTINCT_EN
        exp_sec = 32'd6;
`else
        exp_sec = 32'd7;
`endif
        beat(1, 32'd4, 1'b0);
        beat(1, 32'd7, 1'b0);
        beat(1, 32'd2, 1'b0);
        beat(1, 32'd7, 1'b0);
        beat(1, 32'd6, 1'b1);
        wait_result(1, 32'd7, exp_sec, 16'd5);

        // Stalls: valid gap mid-burst (with a competing requester), then res_ready held low
        beat(3, 32'd8, 1'b0);
        beat(3, 32'd1, 1'b0);
        req_valid[0]   = 1'b1;
        req_data[31:0] = 32'd99;
        req_last[0]    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gap_req_ready", 64'(req_ready), 64'b1000);
            check("gap_busy", 64'(busy), 64'd1);
        end
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
        res_ready    = 1'b0;
        beat(3, 32'd12, 1'b1);
        wait_result(3, 32'd12, 32'd8, 16'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_res_valid", 64'(res_valid), 64'd1);
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_res_id", 64'(res_id), 64'd3);
            check("hold_largest", 64'(res_largest), 64'd12);
            check("hold_second", 64'(res_second), 64'd8);
            check("hold_count", 64'(res_count), 64'd3);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("hold_release_res_valid", 64'(res_valid), 64'd0);
        check("hold_release_busy", 64'(busy), 64'd0);

        // Round-robin: all requesters hold single-beat bursts of value 10+i
        for (int i = 0; i < 4; i++) begin
            req_data[i*32 +: 32] = 32'(10 + i);
        end
        req_last  = 4'hf;
        req_valid = 4'hf;
        got = 0;
        t   = 0;
        while (got < 5 && t < 100) begin
            @(negedge clk);
            t++;
            if (res_valid) begin
                exp_id = got % 4;
                check("rr_id", 64'(res_id), 64'(exp_id));
                check("rr_largest", 64'(res_largest), 64'(10 + exp_id));
                check("rr_second", 64'(res_second), 64'd0);
                check("rr_count", 64'(res_count), 64'd1);
                got++;
            end
        end
        req_valid = '0;
        req_last  = '0;
        check("rr_results", 64'(got), 64'd5);

        // Saturation: 20-beat burst 0..19 into the 4-bit counter instance
        b = 0;
        t = 0;
        @(negedge clk);
        s_valid[0]  = 1'b1;
        s_data[7:0] = 8'(b);
        s_last[0]   = 1'b0;
        while (b < 20 && t < 200) begin
            if (s_ready[0]) begin
                b++;
            end
            @(negedge clk);
            t++;
            if (b < 20) begin
                s_data[7:0] = 8'(b);
                s_last[0]   = (b == 19);
            end
        end
        s_valid = '0;
        s_last  = '0;
        check("sat_res_valid", 64'(s_res_valid), 64'd1);
        check("sat_id", 64'(s_res_id), 64'd0);
        check("sat_count", 64'(s_count), 64'd15);
        check("sat_largest", 64'(s_largest), 64'd19);
        check("sat_second", 64'(s_second), 64'd18);
        @(negedge clk);
        check("sat_busy_after", 64'(s_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
